// File: rtl/dice_roller_if.sv
// Roll request, hold mask and result bus between the dice core and display/score logic.
interface dice_roller_if #(
    parameter int unsigned N_DICE  = 2,
    parameter int unsigned N_FACES = 6
);
    localparam int unsigned FACE_W = $clog2(N_FACES + 1);
    localparam int unsigned SUM_W  = $clog2(N_DICE * N_FACES + 1);

    logic                       button;
    logic [N_DICE-1:0]          hold_mask;
    logic [N_DICE*FACE_W-1:0]   throw;
    logic [SUM_W-1:0]           sum;
    logic                       rolling;
    logic                       done;
    logic [7:0]                 roll_count;

    modport master (
        output button, hold_mask,
        input  throw, sum, rolling, done, roll_count
    );

    modport slave (
        input  button, hold_mask,
        output throw, sum, rolling, done, roll_count
    );
endinterface

// File: rtl/dice_roller.sv
// Multi-die electronic dice: odometer-chained dice advance while the button is held,
// result freezes on release with a done pulse and a saturating roll counter.
module dice_roller #(
    parameter int unsigned N_DICE  = 2,
    parameter int unsigned N_FACES = 6
) (
    input  logic            clk,
    input  logic            reset,
    dice_roller_if.slave    bus
);
    localparam int unsigned FACE_W = $clog2(N_FACES + 1);
    localparam int unsigned SUM_W  = $clog2(N_DICE * N_FACES + 1);
    localparam int unsigned THR_W  = N_DICE * FACE_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROLL,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [THR_W-1:0]   throw_q, throw_d;
    logic [THR_W-1:0]   throw_adv;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [7:0]         count_q, count_d;

    // Odometer increment: the carry skips held dice; a carry off the top is dropped.
    always_comb begin
        logic             carry;
        logic [FACE_W-1:0] die;
        carry     = 1'b1;
        throw_adv = throw_q;
        for (int i = 0; i < int'(N_DICE); i++) begin
            die = throw_q[i*FACE_W +: FACE_W];
            if (!bus.hold_mask[i] && carry) begin
                if (die == FACE_W'(N_FACES)) begin
                    die = FACE_W'(1);
                end else begin
                    die   = die + FACE_W'(1);
                    carry = 1'b0;
                end
            end
            throw_adv[i*FACE_W +: FACE_W] = die;
        end
    end

    always_comb begin
        state_d = state_q;
        throw_d = throw_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.button) begin
                    state_d = S_ROLL;
                    throw_d = throw_adv;
                end
            end
            S_ROLL: begin
                if (bus.button) begin
                    throw_d = throw_adv;
                end else begin
                    state_d = S_DONE;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sum follows the next-state dice so it lands in the same cycle as throw.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < int'(N_DICE); i++) begin
            sum_d = sum_d + SUM_W'(throw_d[i*FACE_W +: FACE_W]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            throw_q <= {N_DICE{FACE_W'(1)}};
            sum_q   <= SUM_W'(N_DICE);
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            throw_q <= throw_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign bus.throw      = throw_q;
    assign bus.sum        = sum_q;
    assign bus.rolling    = (state_q == S_ROLL);
    assign bus.done       = (state_q == S_DONE);
    assign bus.roll_count = count_q;
endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: directed scenarios plus randomized button/hold/reset traffic.
module tb_dice_roller;
    localparam int unsigned N_DICE  = 2;
    localparam int unsigned N_FACES = 6;
    localparam int unsigned FACE_W  = $clog2(N_FACES + 1);

    logic clk;
    logic reset;

    dice_roller_if #(.N_DICE(N_DICE), .N_FACES(N_FACES)) bus ();

    dice_roller #(.N_DICE(N_DICE), .N_FACES(N_FACES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // Reference model: dice as integers, phase 0=idle 1=roll 2=done.
    int m_die [N_DICE];
    int m_phase;
    int m_count;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < int'(N_DICE); i++) m_die[i] = 1;
        m_phase = 0;
        m_count = 0;
    endfunction

    // Unheld dice form a mixed-radix number (digit = value-1); an advance adds one modulo its range.
    function automatic void m_advance(input logic [N_DICE-1:0] mask);
        longint val;
        longint span;
        val  = 0;
        span = 1;
        for (int i = 0; i < int'(N_DICE); i++) begin
            if (!mask[i]) begin
                val  = val + longint'(m_die[i] - 1) * span;
                span = span * N_FACES;
            end
        end
        val = (val + 1) % span;
        for (int i = 0; i < int'(N_DICE); i++) begin
            if (!mask[i]) begin
                m_die[i] = int'(val % N_FACES) + 1;
                val      = val / N_FACES;
            end
        end
    endfunction

    function automatic void m_step(input logic btn, input logic [N_DICE-1:0] mask);
        case (m_phase)
            0: if (btn) begin m_advance(mask); m_phase = 1; end
            1: begin
                if (btn) m_advance(mask);
                else begin
                    m_phase = 2;
                    if (m_count < 255) m_count++;
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    function automatic int dut_die(input int i);
        logic [N_DICE*FACE_W-1:0] t;
        t = bus.throw;
        return int'(t[i*FACE_W +: FACE_W]);
    endfunction

    task automatic compare_all(input string tag);
        int s;
        s = 0;
        for (int i = 0; i < int'(N_DICE); i++) begin
            chk($sformatf("%s_die%0d", tag, i), dut_die(i), m_die[i]);
            s += m_die[i];
        end
        chk({tag, "_sum"},     bus.sum,        s);
        chk({tag, "_rolling"}, bus.rolling,    (m_phase == 1) ? 1 : 0);
        chk({tag, "_done"},    bus.done,       (m_phase == 2) ? 1 : 0);
        chk({tag, "_count"},   bus.roll_count, m_count);
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(input logic btn, input logic [N_DICE-1:0] mask, input string tag);
        bus.button    = btn;
        bus.hold_mask = mask;
        @(posedge clk);
        m_step(btn, mask);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        @(negedge clk);
        compare_all("reset");
        reset = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.button    = 1'b0;
        bus.hold_mask = '0;
        m_reset();
        @(negedge clk);
        compare_all("por");
        chk("por_sum_const", bus.sum, 2);
        reset = 1'b0;

        // Short roll of three advances
        for (int k = 0; k < 3; k++) step(1'b1, 2'b00, "short");
        chk("short_die0_const", dut_die(0), 4);
        chk("short_sum_const", bus.sum, 5);
        step(1'b0, 2'b00, "short_rel");
        chk("short_done_const", bus.done, 1);
        chk("short_count_const", bus.roll_count, 1);
        step(1'b0, 2'b00, "short_idle");

        // Carry into die1 and full wrap after 36 advances
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 2'b00, "carry");
        chk("carry_die1_const", dut_die(1), 2);
        chk("carry_sum_const", bus.sum, 3);
        for (int k = 0; k < 30; k++) step(1'b1, 2'b00, "wrap");
        chk("wrap_sum_const", bus.sum, 2);
        step(1'b0, 2'b00, "wrap_rel");
        step(1'b0, 2'b00, "wrap_idle");

        // Hold die0 at 4, advance die1 twice; then hold everything
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 2'b00, "hprep");
        step(1'b0, 2'b00, "hprep_rel");
        step(1'b0, 2'b00, "hprep_idle");
        for (int k = 0; k < 2; k++) step(1'b1, 2'b01, "hold1");
        chk("hold1_die0_const", dut_die(0), 4);
        chk("hold1_die1_const", dut_die(1), 3);
        chk("hold1_sum_const", bus.sum, 7);
        step(1'b0, 2'b01, "hold1_rel");
        step(1'b0, 2'b01, "hold1_idle");
        for (int k = 0; k < 5; k++) step(1'b1, 2'b11, "holdall");
        step(1'b0, 2'b11, "holdall_rel");
        chk("holdall_count_const", bus.roll_count, 3);
        chk("holdall_sum_const", bus.sum, 7);
        // Held button in DONE must not restart until IDLE
        step(1'b1, 2'b00, "done_btn");
        step(1'b1, 2'b00, "restart");
        step(1'b0, 2'b00, "restart_rel");
        step(1'b0, 2'b00, "restart_idle");

        // Async reset between edges while rolling
        for (int k = 0; k < 4; k++) step(1'b1, 2'b00, "ar_roll");
        #2 reset = 1'b1;
        m_reset();
        #1 compare_all("ar_async");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 2'b00, "ar_resume");
        step(1'b0, 2'b00, "ar_rel");
        step(1'b0, 2'b00, "ar_idle");

        // Roll counter saturation
        do_reset();
        for (int r = 0; r < 257; r++) begin
            step(1'b1, 2'b00, "sat_roll");
            step(1'b0, 2'b00, "sat_done");
            step(1'b0, 2'b00, "sat_idle");
            if (r == 255) chk("sat_255_const", bus.roll_count, 255);
        end
        chk("sat_257_const", bus.roll_count, 255);

        // Randomized traffic with occasional synchronous-time resets
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic             b;
            logic [N_DICE-1:0] m;
            b = ($urandom_range(0, 3) != 0);
            m = N_DICE'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(b, m, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Multi-die electronic dice, generalising the single 3-bit dice to N_DICE dice of N_FACES faces each.
- While button is held, the dice advance as an odometer chain; on release the result freezes, a one-cycle done pulse is issued and the roll counter increments.
- Per-die hold mask gives keep-and-reroll games. Outputs feed the display/score logic.

Parameters:
- N_DICE, 2, number of dice (1..8).
- N_FACES, 6, faces per die; values 1..N_FACES (2..15).
- FACE_W, $clog2(N_FACES+1), bits per die value; derived, not overridden.
- SUM_W, $clog2(N_DICE*N_FACES+1), width of sum; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- button  in  1  roll request, sampled directly at clk edge (already synchronous).
- hold_mask  in  N_DICE  bit i=1 freezes die i.
- throw  out  N_DICE*FACE_W  die i value at [i*FACE_W +: FACE_W].
- sum  out  SUM_W  sum of all die values, always consistent with throw.
- rolling  out  1  high while in ROLL.
- done  out  1  one-cycle pulse after release.
- roll_count  out  8  completed rolls, saturating.

Behaviour:
- Reset (async, immediate, also mid-roll): every die=1, sum=N_DICE, rolling=0, done=0, roll_count=0, state=IDLE.
- FSM states: IDLE, ROLL, DONE. All outputs registered.
- IDLE: edge with button=1 -> ROLL, and the dice advance on that same edge. Edge with button=0 -> stay in IDLE, no change.
- ROLL:
  - Edge with button=1 -> stay in ROLL, dice advance.
  - Edge with button=0 -> DONE, no advance; roll_count += 1, saturating at 255.
- DONE: done=1 for exactly this cycle. Next edge -> IDLE unconditionally, no advance, even if button=1. A held button only starts a new roll from IDLE on the following edge.
- rolling=1 iff state==ROLL. done=1 iff state==DONE.
- Advance rule (odometer):
  - The lowest-index unheld die increments by 1.
  - A die at N_FACES wraps to 1 and carries to the next unheld die above it. Held dice are skipped by the carry and never change.
  - A carry out of the highest unheld die is discarded: the full state wraps to all-unheld-dice=1 after N_FACES^(unheld count) advances.
- All dice held: button cycles the FSM normally (rolling, done, roll_count all behave), throw unchanged.
- hold_mask is sampled each edge; a change mid-roll takes effect on the next edge.
- Die values are always in 1..N_FACES; 0 or values above N_FACES never appear.
- sum is computed from next-state die values and registered with them: same-cycle consistency with throw, no extra latency.

Test Plan:
- Defaults (N_DICE=2, N_FACES=6).
- Reset: assert reset -> throw die0=1, die1=1, sum=2, rolling=0, done=0, roll_count=0.
- Short roll from reset, hold_mask=00, button high for 3 edges then low:
  - after 3 edges: die0=4, die1=1, sum=5, rolling=1;
  - next edge: done=1 for one cycle, roll_count=1;
  - following edge: done=0, state IDLE, values held.
- Carry and full wrap:
  - from reset, button high 6 edges -> die0=1, die1=2, sum=3;
  - 36 edges total -> die0=1, die1=1, sum=2.
- Hold: die0=4, die1=1, hold_mask=01, button high 2 edges -> die0=4, die1=3, sum=7. hold_mask=11 plus a 5-edge roll -> values unchanged, done pulses, roll_count increments.
- Async reset mid-roll: button high, reset asserted between edges -> all outputs return to reset values before the next clk edge; state resumes from IDLE after release.
- Saturation: 256 complete 1-edge rolls -> roll_count=255; the 257th roll leaves it at 255. done still pulses every roll.
